// File: rtl/cpu_switch_pkg.sv
// Shared types and helpers for the CPU switch arbiter.
// Holds the CPU FSM state enum, index-width helper and best-CPU search.
package cpu_switch_pkg;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    ALL_FAIL
  } cpu_state_e;

  localparam int MAX_N = 8;
  localparam int MAX_W = 32;
  localparam int IDX_MAX_W = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Healthy CPU with the minimum count; strict < keeps the lowest index.
  function automatic logic [IDX_MAX_W-1:0] best_cpu(
    input logic [MAX_N-1:0]            ok,
    input logic [MAX_N-1:0][MAX_W-1:0] cnt
  );
    logic [IDX_MAX_W-1:0] b;
    logic [MAX_W-1:0]     m;
    logic                 found;
    b     = '0;
    m     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      if (ok[i] && (!found || cnt[i] < m)) begin
        b     = IDX_MAX_W'(i);
        m     = cnt[i];
        found = 1'b1;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/cpu_switch_arbiter_health.sv
// health_debounce: 2-FF synchronizer plus level debouncer for one io_ok line.
// Ports: clk, rst_n, io_ok_i (async), err_o (debounced error), rise_o (err edge).
module health_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic io_ok_i,
  output logic err_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          s1_q;
  logic          s2_q;
  logic          ok_q;
  logic          err_d1_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      ok_q     <= 1'b1;
      err_d1_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= io_ok_i;
      s2_q     <= s1_q;
      err_d1_q <= ~ok_q;
      if (s2_q == ok_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYC - 1)) begin
        ok_q  <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign err_o  = ~ok_q;
  assign rise_o = ~ok_q & ~err_d1_q;

endmodule

// File: rtl/cpu_switch_arbiter.sv
// N-way CPU redundancy controller with error counting and command-link vote.
// In: clk, rst_n, io_ok, force_swi/idx, byte_stb. Out: sel, sel_oh, flags, err_cnt, ch_sel.
module cpu_switch_arbiter
  import cpu_switch_pkg::*;
#(
  parameter int N_CPU     = 2,
  parameter int N_CH      = 2,
  parameter int ERR_W     = 8,
  parameter int DEB_CYC   = 16,
  parameter int MARGIN    = 2,
  parameter int DWELL_CYC = 1024,
  parameter int GAP_CYC   = 20000,
  parameter int BYTE_W    = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CPU-1:0]       io_ok,
  input  logic                   force_swi,
  input  logic [idx_w(N_CPU)-1:0] force_idx,
  input  logic [N_CH-1:0]        byte_stb,
  output logic [idx_w(N_CPU)-1:0] sel,
  output logic [N_CPU-1:0]       sel_oh,
  output logic                   all_fail,
  output logic                   switch_evt,
  output logic                   force_nak,
  output logic [N_CPU*ERR_W-1:0] err_cnt,
  output logic [idx_w(N_CH)-1:0] ch_sel,
  output logic                   frame_end
);

  localparam int CPU_W  = idx_w(N_CPU);
  localparam int CH_W   = idx_w(N_CH);
  localparam int DW_W   = $clog2(DWELL_CYC + 1);
  localparam int IDLE_W = $clog2(GAP_CYC + 1);

  logic [N_CPU-1:0] err;
  logic [N_CPU-1:0] rise;

  for (genvar g = 0; g < N_CPU; g++) begin : g_hd
    health_debounce #(.DEB_CYC(DEB_CYC)) u_hd (
      .clk     (clk),
      .rst_n   (rst_n),
      .io_ok_i (io_ok[g]),
      .err_o   (err[g]),
      .rise_o  (rise[g])
    );
  end

  cpu_state_e       state_q, state_d;
  logic [CPU_W-1:0] sel_q, sel_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [ERR_W-1:0] cnt_q [N_CPU];
  logic [ERR_W-1:0] cnt_d [N_CPU];
  logic             evt_q, nak_q, nak_d, clr;

  logic [MAX_N-1:0]            ok_pad;
  logic [MAX_N-1:0][MAX_W-1:0] cnt_pad;
  logic [CPU_W-1:0]            best;
  logic                        any_ok, sel_bad, pref, ovf;

  always_comb begin
    ok_pad  = '0;
    cnt_pad = '0;
    for (int i = 0; i < N_CPU; i++) begin
      ok_pad[i]  = ~err[i];
      cnt_pad[i] = MAX_W'(cnt_q[i]);
    end
  end

  assign best    = CPU_W'(best_cpu(ok_pad, cnt_pad));
  assign any_ok  = |ok_pad;
  assign sel_bad = ~ok_pad[IDX_MAX_W'(sel_q)];
  assign pref    = cnt_pad[IDX_MAX_W'(sel_q)] >=
                   cnt_pad[IDX_MAX_W'(best)] + MAX_W'(MARGIN);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    nak_d   = 1'b0;
    clr     = 1'b0;
    if (state_q == HOLD && dwell_q != '0) dwell_d = dwell_q - DW_W'(1);
    unique case (state_q)
      RUN: begin
        if (!any_ok) begin
          state_d = ALL_FAIL;
        end else if (sel_bad || pref) begin
          sel_d   = best;
          state_d = HOLD;
          dwell_d = DW_W'(DWELL_CYC);
        end
      end
      HOLD: begin
        if (!any_ok) begin
          state_d = ALL_FAIL;
        end else if (sel_bad) begin
          sel_d   = best;
          dwell_d = DW_W'(DWELL_CYC);
        end else if (dwell_q == '0) begin
          state_d = RUN;
        end
      end
      ALL_FAIL: begin
        if (any_ok) begin
          sel_d   = best;
          state_d = HOLD;
          dwell_d = DW_W'(DWELL_CYC);
        end
      end
      default: state_d = RUN;
    endcase
    // Force outranks any automatic decision made above.
    if (force_swi) begin
      if (ok_pad[IDX_MAX_W'(force_idx)]) begin
        sel_d   = force_idx;
        state_d = HOLD;
        dwell_d = DW_W'(DWELL_CYC);
        clr     = 1'b1;
      end else begin
        nak_d = 1'b1;
      end
    end
  end

  // Halve everyone before an overflowing increment so ordering survives.
  always_comb begin
    ovf = 1'b0;
    for (int i = 0; i < N_CPU; i++) begin
      if (rise[i] && cnt_q[i] == '1) ovf = 1'b1;
    end
    for (int i = 0; i < N_CPU; i++) begin
      cnt_d[i] = clr ? '0 :
                 ((ovf ? (cnt_q[i] >> 1) : cnt_q[i]) + ERR_W'(rise[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      sel_q   <= '0;
      dwell_q <= '0;
      evt_q   <= 1'b0;
      nak_q   <= 1'b0;
      for (int i = 0; i < N_CPU; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
      evt_q   <= (sel_d != sel_q);
      nak_q   <= nak_d;
      for (int i = 0; i < N_CPU; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_CPU; i++) begin
      sel_oh[i] = (sel_q == CPU_W'(i));
      err_cnt[i*ERR_W +: ERR_W] = cnt_q[i];
    end
  end

  assign sel        = sel_q;
  assign all_fail   = (state_q == ALL_FAIL);
  assign switch_evt = evt_q;
  assign force_nak  = nak_q;

  logic [IDLE_W-1:0] idle_q [N_CH];
  logic [BYTE_W-1:0] byte_q [N_CH];
  logic              armed_q, fe_q, gap, fire;
  logic [CH_W-1:0]   ch_q, win;
  logic [BYTE_W-1:0] winv;

  always_comb begin
    gap  = 1'b1;
    win  = ch_q;
    winv = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (idle_q[j] < IDLE_W'(GAP_CYC)) gap = 1'b0;
      if (CH_W'(j) == ch_q) winv = byte_q[j];
    end
    for (int j = 0; j < N_CH; j++) begin
      if (byte_q[j] > winv) begin
        winv = byte_q[j];
        win  = CH_W'(j);
      end
    end
  end

  // armed_q limits frame_end to one pulse per gap that followed traffic.
  assign fire = gap & armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      fe_q    <= 1'b0;
      ch_q    <= '0;
      for (int j = 0; j < N_CH; j++) begin
        idle_q[j] <= '0;
        byte_q[j] <= '0;
      end
    end else begin
      fe_q <= fire;
      if (fire) ch_q <= win;
      if (|byte_stb) armed_q <= 1'b1;
      else if (fire) armed_q <= 1'b0;
      for (int j = 0; j < N_CH; j++) begin
        if (byte_stb[j]) idle_q[j] <= '0;
        else if (idle_q[j] != IDLE_W'(GAP_CYC)) idle_q[j] <= idle_q[j] + IDLE_W'(1);
        if (fe_q) byte_q[j] <= BYTE_W'(byte_stb[j]);
        else if (byte_stb[j] && byte_q[j] != '1) byte_q[j] <= byte_q[j] + BYTE_W'(1);
      end
    end
  end

  assign ch_sel    = ch_q;
  assign frame_end = fe_q;

endmodule

// File: tb/tb_cpu_switch_arbiter.sv
// Self-checking bench for cpu_switch_arbiter (3 CPUs, 2 channels).
// Scenario tasks push expectations to a queue and pop them on DUT events.
module tb_cpu_switch_arbiter;

  localparam int N_CPU  = 3;
  localparam int N_CH   = 2;
  localparam int ERR_W  = 8;
  localparam int DEB    = 4;
  localparam int MARGIN = 2;
  localparam int DWELL  = 16;
  localparam int GAP    = 40;
  localparam int BYTE_W = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  io_ok;
  logic        force_swi;
  logic [1:0]  force_idx;
  logic [1:0]  byte_stb;
  logic [1:0]  sel;
  logic [2:0]  sel_oh;
  logic        all_fail, switch_evt, force_nak, frame_end;
  logic [23:0] err_cnt;
  logic [0:0]  ch_sel;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int n_evt = 0;
  int n_fe = 0;

  cpu_switch_arbiter #(
    .N_CPU(N_CPU), .N_CH(N_CH), .ERR_W(ERR_W), .DEB_CYC(DEB),
    .MARGIN(MARGIN), .DWELL_CYC(DWELL), .GAP_CYC(GAP), .BYTE_W(BYTE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_ok(io_ok),
    .force_swi(force_swi), .force_idx(force_idx), .byte_stb(byte_stb),
    .sel(sel), .sel_oh(sel_oh), .all_fail(all_fail),
    .switch_evt(switch_evt), .force_nak(force_nak), .err_cnt(err_cnt),
    .ch_sel(ch_sel), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    if (switch_evt) n_evt++;
    if (frame_end) n_fe++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pk(input int c0, input int c1, input int c2);
    return {8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_switch(input int bound, output int cyc);
    cyc = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (switch_evt) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic pulse_err(input int i, input int n);
    io_ok[i] = 1'b0;
    tick(n);
    io_ok[i] = 1'b1;
    tick(n);
  endtask

  task automatic do_force(input int idx);
    force_swi = 1'b1;
    force_idx = 2'(idx);
    @(negedge clk);
    force_swi = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; io_ok = 3'b111; force_swi = 1'b0;
    force_idx = '0; byte_stb = '0;
    tick(3);
    checks++;
    if (sel !== 2'd0 || sel_oh !== 3'b001) begin
      failures++;
      $display("FAIL reset_sel got=%0d/%b exp=0/001", sel, sel_oh);
    end
    checks++;
    if (err_cnt !== 24'd0 || ch_sel !== 1'b0) begin
      failures++;
      $display("FAIL reset_cnt got=%h/%0d exp=0/0", err_cnt, ch_sel);
    end
    checks++;
    if ({all_fail, switch_evt, force_nak, frame_end} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000",
               {all_fail, switch_evt, force_nak, frame_end});
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_err_switch;
    int cyc, e, n0;
    n0 = n_evt;
    exp_q.push_back(1);
    io_ok[0] = 1'b0;
    wait_switch(30, cyc);
    checks++;
    if (cyc != DEB + 3) begin
      failures++;
      $display("FAIL err_latency got=%0d exp=%0d", cyc, DEB + 3);
    end
    e = exp_q.pop_front();
    checks++;
    if (sel !== 2'(e) || sel_oh !== 3'b010) begin
      failures++;
      $display("FAIL err_sel got=%0d/%b exp=%0d/010", sel, sel_oh, e);
    end
    checks++;
    if (err_cnt !== pk(1, 0, 0)) begin
      failures++;
      $display("FAIL err_cnt got=%h exp=%h", err_cnt, pk(1, 0, 0));
    end
    io_ok[0] = 1'b1;
    tick(DWELL + 12);
    checks++;
    if (sel !== 2'd1 || n_evt != n0 + 1) begin
      failures++;
      $display("FAIL err_settle got sel=%0d evts=%0d exp sel=1 evts=%0d",
               sel, n_evt - n0, 1);
    end
  endtask

  task automatic test_glitch;
    int n0;
    n0 = n_evt;
    io_ok[1] = 1'b0;
    tick(2);
    io_ok[1] = 1'b1;
    tick(15);
    checks++;
    if (err_cnt !== pk(1, 0, 0) || sel !== 2'd1 || n_evt != n0) begin
      failures++;
      $display("FAIL glitch got cnt=%h sel=%0d evts=%0d exp cnt=%h sel=1 evts=0",
               err_cnt, sel, n_evt - n0, pk(1, 0, 0));
    end
  endtask

  task automatic test_force;
    int e, n0;
    io_ok[2] = 1'b0;
    tick(10);
    checks++;
    if (err_cnt !== pk(1, 0, 1) || sel !== 2'd1) begin
      failures++;
      $display("FAIL force_pre got cnt=%h sel=%0d exp cnt=%h sel=1",
               err_cnt, sel, pk(1, 0, 1));
    end
    do_force(2);
    checks++;
    if (force_nak !== 1'b1 || sel !== 2'd1 || err_cnt !== pk(1, 0, 1)) begin
      failures++;
      $display("FAIL force_bad got nak=%b sel=%0d cnt=%h exp nak=1 sel=1 cnt=%h",
               force_nak, sel, err_cnt, pk(1, 0, 1));
    end
    tick(1);
    checks++;
    if (force_nak !== 1'b0) begin
      failures++;
      $display("FAIL force_nak_pulse got=%b exp=0", force_nak);
    end
    do_force(3);
    checks++;
    if (force_nak !== 1'b1 || sel !== 2'd1) begin
      failures++;
      $display("FAIL force_range got nak=%b sel=%0d exp nak=1 sel=1", force_nak, sel);
    end
    exp_q.push_back(0);
    do_force(0);
    e = exp_q.pop_front();
    checks++;
    if (switch_evt !== 1'b1 || sel !== 2'(e) || err_cnt !== 24'd0 || force_nak !== 1'b0) begin
      failures++;
      $display("FAIL force_ok got evt=%b sel=%0d cnt=%h nak=%b exp evt=1 sel=%0d cnt=0 nak=0",
               switch_evt, sel, err_cnt, force_nak, e);
    end
    tick(1);
    n0 = n_evt;
    do_force(0);
    checks++;
    if (force_nak !== 1'b0 || sel !== 2'd0) begin
      failures++;
      $display("FAIL force_same got nak=%b sel=%0d exp nak=0 sel=0", force_nak, sel);
    end
    tick(2);
    checks++;
    if (n_evt != n0) begin
      failures++;
      $display("FAIL force_same_evt got=%0d exp=0", n_evt - n0);
    end
    io_ok[2] = 1'b1;
    tick(10);
  endtask

  task automatic test_margin;
    int cyc, e;
    repeat (5) pulse_err(0, 8);
    checks++;
    if (err_cnt !== pk(5, 0, 0) || sel !== 2'd1) begin
      failures++;
      $display("FAIL margin_build got cnt=%h sel=%0d exp cnt=%h sel=1",
               err_cnt, sel, pk(5, 0, 0));
    end
    io_ok[2] = 1'b0;
    tick(8);
    exp_q.push_back(0);
    io_ok[1] = 1'b0;
    wait_switch(20, cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc < 0 || sel !== 2'(e) || err_cnt !== pk(5, 1, 1)) begin
      failures++;
      $display("FAIL margin_to0 got cyc=%0d sel=%0d cnt=%h exp sel=%0d cnt=%h",
               cyc, sel, err_cnt, e, pk(5, 1, 1));
    end
    io_ok[1] = 1'b1;
    io_ok[2] = 1'b1;
    exp_q.push_back(1);
    wait_switch(DWELL + 10, cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc < DWELL || cyc > DWELL + 3) begin
      failures++;
      $display("FAIL margin_dwell got=%0d exp=%0d..%0d", cyc, DWELL, DWELL + 3);
    end
    checks++;
    if (sel !== 2'(e) || err_cnt !== pk(5, 1, 1)) begin
      failures++;
      $display("FAIL margin_sel got sel=%0d cnt=%h exp sel=%0d cnt=%h",
               sel, err_cnt, e, pk(5, 1, 1));
    end
  endtask

  task automatic test_all_fail;
    int cyc, e, n0;
    n0 = n_evt;
    io_ok = 3'b000;
    tick(10);
    checks++;
    if (all_fail !== 1'b1 || sel !== 2'd1 || n_evt != n0) begin
      failures++;
      $display("FAIL allfail_enter got af=%b sel=%0d evts=%0d exp af=1 sel=1 evts=0",
               all_fail, sel, n_evt - n0);
    end
    checks++;
    if (err_cnt !== pk(6, 2, 2)) begin
      failures++;
      $display("FAIL allfail_cnt got=%h exp=%h", err_cnt, pk(6, 2, 2));
    end
    exp_q.push_back(2);
    io_ok[2] = 1'b1;
    wait_switch(20, cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc != DEB + 3 || sel !== 2'(e) || all_fail !== 1'b0) begin
      failures++;
      $display("FAIL allfail_exit got cyc=%0d sel=%0d af=%b exp cyc=%0d sel=%0d af=0",
               cyc, sel, all_fail, DEB + 3, e);
    end
    io_ok = 3'b111;
    tick(10);
  endtask

  task automatic test_overflow;
    do_force(0);
    tick(2);
    repeat (40) pulse_err(0, 7);
    repeat (255) pulse_err(1, 7);
    checks++;
    if (err_cnt !== pk(40, 255, 0)) begin
      failures++;
      $display("FAIL ovf_pre got=%h exp=%h", err_cnt, pk(40, 255, 0));
    end
    pulse_err(1, 7);
    checks++;
    if (err_cnt !== pk(20, 128, 0)) begin
      failures++;
      $display("FAIL ovf_halve got=%h exp=%h", err_cnt, pk(20, 128, 0));
    end
  endtask

  task automatic send_frame(input int a, input int b, input int expv);
    int cyc, e, n;
    n = (a > b) ? a : b;
    exp_q.push_back(expv);
    for (int k = 0; k < n; k++) begin
      byte_stb = {1'(k < b), 1'(k < a)};
      @(negedge clk);
    end
    byte_stb = '0;
    cyc = -1;
    for (int k = 1; k <= GAP + 10; k++) begin
      @(negedge clk);
      if (frame_end) begin
        cyc = k;
        break;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (cyc != GAP + 1) begin
      failures++;
      $display("FAIL frame_latency got=%0d exp=%0d", cyc, GAP + 1);
    end
    checks++;
    if (ch_sel !== 1'(e)) begin
      failures++;
      $display("FAIL frame_vote a=%0d b=%0d got=%0d exp=%0d", a, b, ch_sel, e);
    end
  endtask

  task automatic test_channel;
    int n0;
    send_frame(7, 9, 1);
    n0 = n_fe;
    tick(2 * GAP);
    checks++;
    if (n_fe != n0) begin
      failures++;
      $display("FAIL frame_repeat got=%0d exp=0", n_fe - n0);
    end
    send_frame(4, 4, 1);
    send_frame(3, 2, 0);
  endtask

  task automatic test_reset_mid;
    int n0;
    do_force(1);
    byte_stb = 2'b01;
    tick(3);
    byte_stb = '0;
    tick(2);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel !== 2'd0 || err_cnt !== 24'd0 || all_fail !== 1'b0 || ch_sel !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got sel=%0d cnt=%h af=%b ch=%0d exp 0/0/0/0",
               sel, err_cnt, all_fail, ch_sel);
    end
    tick(2);
    rst_n = 1'b1;
    n0 = n_fe;
    tick(GAP + 10);
    checks++;
    if (n_fe != n0 || sel !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_frame got fe=%0d sel=%0d exp fe=0 sel=0", n_fe - n0, sel);
    end
  endtask

  initial begin
    test_reset;
    test_err_switch;
    test_glitch;
    test_force;
    test_margin;
    test_all_fail;
    test_overflow;
    test_channel;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
